// File: rtl/output_gater.sv
// Requantises 16 x int16 result vectors to int8, packs two vectors per 256-bit word,
// buffers words in a small FIFO and streams them to the output buffer with auto-incrementing addresses.
module output_gater #(
   parameter int LANES      = 16,
   parameter int IN_W       = 16,
   parameter int OUT_W      = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [15:0]               cfg_num_vec,
   input  logic [ADDR_W-1:0]         cfg_base_addr,
   input  logic [3:0]                cfg_shift,
   input  logic                      cfg_relu_en,
   input  logic                      in_valid,
   input  logic [LANES*IN_W-1:0]     in_sum,
   output logic                      wr_valid,
   input  logic                      wr_ready,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [2*LANES*OUT_W-1:0]  wr_data,
   output logic                      busy,
   output logic                      done,
   output logic                      err_overflow,
   output logic                      err_unexp
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int HALF_W = LANES * OUT_W;
   localparam int WORD_W = 2 * HALF_W;
   localparam int EXT_W  = IN_W + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(1 << (OUT_W - 1)));

   logic [1:0]          state_reg, state_next;
   logic [15:0]         num_vec_reg;
   logic [3:0]          shift_reg;
   logic                relu_reg;
   logic [15:0]         vec_cnt_reg;
   logic [ADDR_W-1:0]   addr_reg;

   logic                s1_valid_reg;
   logic [HALF_W-1:0]   s1_data_reg;
   logic                s1_odd_reg;
   logic                s1_last_reg;
   logic [HALF_W-1:0]   half_reg;

   logic [WORD_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]    count_reg, count_next;

   logic                done_reg, done_next;
   logic                err_overflow_reg, err_unexp_reg;

   logic [HALF_W-1:0]   quant_vec;
   logic                accept, last_vec, full, pop, push_req, push, drop;
   logic [WORD_W-1:0]   push_word;

   // Per-lane requantisation uses the configuration latched at job start.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic signed [EXT_W-1:0] x_ext;
         logic        [EXT_W-1:0] rnd;
         logic signed [EXT_W-1:0] sum;
         logic signed [EXT_W-1:0] val;
         logic        [OUT_W-1:0] q;

         always_comb begin
            x_ext = {in_sum[gi*IN_W + IN_W - 1], in_sum[gi*IN_W +: IN_W]};
            rnd   = (shift_reg == 4'd0) ? '0 : (EXT_W'(1) << (shift_reg - 4'd1));
            sum   = x_ext + $signed(rnd);
            val   = sum >>> shift_reg;
            if (relu_reg && (val < 0)) begin
               val = '0;
            end
            if (val > SAT_MAX) begin
               q = SAT_MAX[OUT_W-1:0];
            end else if (val < SAT_MIN) begin
               q = SAT_MIN[OUT_W-1:0];
            end else begin
               q = val[OUT_W-1:0];
            end
         end

         assign quant_vec[gi*OUT_W +: OUT_W] = q;
      end
   endgenerate

   always_comb begin
      accept    = in_valid && (state_reg == ST_RUN);
      last_vec  = (vec_cnt_reg == (num_vec_reg - 16'd1));
      wr_valid  = (count_reg != '0);
      full      = (count_reg == CNT_W'(FIFO_DEPTH));
      pop       = wr_valid && wr_ready;
      push_req  = s1_valid_reg && (s1_odd_reg || s1_last_reg);
      push      = push_req && (!full || pop);
      drop      = push_req && full && !pop;
      push_word = s1_odd_reg ? {s1_data_reg, half_reg} : {{HALF_W{1'b0}}, s1_data_reg};

      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase

      // Done fires on the edge after which nothing is left in flight.
      done_next  = (state_reg == ST_DRAIN) && (count_next == '0);
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (start)              state_next = ST_RUN;
         ST_RUN:   if (accept && last_vec) state_next = ST_DRAIN;
         ST_DRAIN: if (done_next)          state_next = ST_IDLE;
         default:                          state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= ST_IDLE;
         num_vec_reg      <= '0;
         shift_reg        <= '0;
         relu_reg         <= 1'b0;
         vec_cnt_reg      <= '0;
         addr_reg         <= '0;
         s1_valid_reg     <= 1'b0;
         s1_data_reg      <= '0;
         s1_odd_reg       <= 1'b0;
         s1_last_reg      <= 1'b0;
         half_reg         <= '0;
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
         count_reg        <= '0;
         done_reg         <= 1'b0;
         err_overflow_reg <= 1'b0;
         err_unexp_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= done_next;
         count_reg <= count_next;

         if ((state_reg == ST_IDLE) && start) begin
            num_vec_reg <= cfg_num_vec;
            shift_reg   <= cfg_shift;
            relu_reg    <= cfg_relu_en;
            vec_cnt_reg <= '0;
            addr_reg    <= cfg_base_addr;
         end else begin
            if (accept) vec_cnt_reg <= vec_cnt_reg + 16'd1;
            if (pop)    addr_reg    <= addr_reg + ADDR_W'(1);
         end

         s1_valid_reg <= accept;
         if (accept) begin
            s1_data_reg <= quant_vec;
            s1_odd_reg  <= vec_cnt_reg[0];
            s1_last_reg <= last_vec;
         end
         if (s1_valid_reg && !s1_odd_reg && !s1_last_reg) begin
            half_reg <= s1_data_reg;
         end

         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);

         err_overflow_reg <= err_overflow_reg | drop;
         err_unexp_reg    <= err_unexp_reg | (in_valid && !accept);
      end
   end

   // Storage has no reset; emptiness is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= push_word;
      end
   end

   assign wr_data      = wr_valid ? fifo_mem[rd_ptr_reg] : '0;
   assign wr_addr      = addr_reg;
   assign busy         = (state_reg != ST_IDLE);
   assign done         = done_reg;
   assign err_overflow = err_overflow_reg;
   assign err_unexp    = err_unexp_reg;

endmodule
